uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver, 8N1, LSB first; the receive counterpart of the UART at uart_base_addr.
- Samples the asynchronous rx line on the core clock using a bit counter derived from clks_per_bit.
- Delivers bytes through a small FIFO with a valid/ready handshake to the UART register interface.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, configure::clks_per_bit (216 at 25 MHz / 115200), bit period minus 1 in clocks.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2, minimum 2.

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous active-low reset.
- rx  in  1  asynchronous serial input; idle high.
- rx_valid  out  1  FIFO non-empty; rx_data is valid.
- rx_data  out  8  head-of-FIFO byte.
- rx_ready  in  1  consumer pops the head when rx_valid && rx_ready.
- frame_err  out  1  sticky; set on a bad stop bit.
- overrun  out  1  sticky; set when a byte arrives with the FIFO full.
- err_clear  in  1  clears frame_err and overrun.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM goes to IDLE; FIFO is emptied.
  - rx_valid=0, rx_data=0, frame_err=0, overrun=0.
  - Synchronizer flops are preset to 1.
  - Reset mid-frame abandons the frame; no byte is written.
- Synchronizer: rx passes through 2 flops (rx_s). All decisions use rx_s.
- Counters:
  - Baud counter runs 0..CLKS_PER_BIT.
  - Half-bit point is CLKS_PER_BIT/2 (integer divide).
  - Bit index runs 0..7.
- FSM:
  - IDLE: on rx_s==0, clear the counter and go to START.
  - START: at the half-bit point, if rx_s==0 clear the counter and go to DATA; otherwise treat it as a glitch and return to IDLE.
  - DATA: at count==CLKS_PER_BIT (mid-bit), shift rx_s into bit[index], which is LSB first. After index 7 go to STOP.
  - STOP: at mid-bit, sample rx_s.
    - 1: push the byte.
    - 0: set frame_err, discard the byte, go to WAIT.
    - In either case the next state is IDLE (or WAIT on error).
  - WAIT: stay until rx_s==1, so that a break does not retrigger; then go to IDLE.
- Latency: a byte becomes visible (rx_valid=1) the cycle after the stop-bit mid-sample, about 9.5 bit times after the start-bit falling edge, plus 2 synchronizer cycles.
- FIFO:
  - Full: a push is dropped and overrun is set; existing data is preserved.
  - Empty: a pop is ignored.
  - Push and pop in the same cycle when full: the pop occurs, the push succeeds, and overrun is not set.
  - Push and pop in the same cycle when empty: the push lands, and rx_valid rises the next cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full/empty are decided by pointer MSB comparison.
- rx_data holds the head value while rx_valid=1 and is stable until popped.
- Error flags:
  - err_clear takes priority over a same-cycle set, so the flag clears.
  - Flags never auto-clear.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: an extra PARITY state between DATA and STOP samples an even-parity bit.
  - On mismatch, the sticky output parity_err (out, 1, reset 0, cleared by err_clear) is set and the byte is discarded.
- Not defined:
  - No PARITY state and no parity_err port; the frame is 8N1 as above.

Decomposition:
- Shared package (configure or a uart package):
  - FSM state enum: IDLE, START, DATA, [PARITY], STOP, WAIT.
  - clks_per_bit default.
  - FIFO depth constant.
- Sub-module uart_rx_fifo: synchronous FIFO with push/pop/full/empty, parameterized by width and depth. It is reusable by a future TX buffer.

Test Plan:
- Send 0xA5, 8N1, at CLKS_PER_BIT=216 with rx_ready=1 → rx_valid pulses with rx_data=0xA5 about 2065 clocks after the falling edge; frame_err=0.
- A 50-clock low glitch on idle rx → no byte; FSM back in IDLE; rx_valid stays 0.
- Send 0x3C with the stop bit forced low, then hold low for 3 bit times, then idle → frame_err=1, no push, no retrigger. Then err_clear=1 for 1 cycle → frame_err=0.
- With rx_ready=0, send 0x01,0x02,0x03,0x04,0x05 at FIFO_DEPTH=4 → rx_valid=1 and overrun=1. Then raise rx_ready → pops return 0x01..0x04 in order; 0x05 is lost.
- Send a byte while reset pulses low at bit 4 → no byte; after release, the next frame 0x7E is received correctly.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 0 (wrong; even parity requires 1) → parity_err=1, no push. Send 0x07 with parity bit 1 → rx_data=0x07.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM states and default configuration.
// Define UART_RX_PARITY_EN to add the even-parity state (8E1 framing).
package uart_rx_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 216;
    localparam int unsigned FIFO_DEPTH_DEFAULT   = 4;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWait
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with push/pop/full/empty; pointers carry one extra wrap bit.
// DEPTH must be a power of two, at least 2.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, with receive FIFO and sticky error flags.
// Define UART_RX_PARITY_EN for 8E1 framing and the parity_err output.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    input  logic       err_clear
);

    localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [1:0]      sync_q;
    logic            rx_s;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push, frame_set, overrun_set;
    logic            frame_err_q, overrun_q;
    logic            fifo_full, fifo_empty;
    logic            bit_done;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d, parity_set, parity_err_q;
`endif

    assign rx_s     = sync_q[1];
    assign bit_done = (cnt_q == CntFull);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        parity_set = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StData: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = StStop;
                    if (rx_s != ^shift_q) begin
                        par_bad_d  = 1'b1;
                        parity_set = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
`endif
            StStop: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        push = !par_bad_q;
`else
                        push = 1'b1;
`endif
                        state_d = StIdle;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = StWait;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            // Hold off until the line returns high so a break cannot start a new frame.
            StWait: begin
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A full FIFO is always non-empty, so rx_ready alone means a pop is freeing a slot.
    assign overrun_set = push && fifo_full && !rx_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q      <= 2'b11;
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], rx};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= err_clear ? 1'b0 : (frame_err_q | frame_set);
            overrun_q   <= err_clear ? 1'b0 : (overrun_q | overrun_set);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= err_clear ? 1'b0 : (parity_err_q | parity_set);
        end
    end

    assign parity_err = parity_err_q;
`endif

    uart_rx_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_data(shift_q),
        .pop      (rx_ready),
        .pop_data (rx_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rx_valid  = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, a cycle-level reference model and literal spot checks.
// Define UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_rx;

    localparam int C   = 216;
    localparam int D   = 4;
    localparam int BIT = C + 1;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    // Edges from the falling edge to the stop-bit sample: 2 sync + idle detect,
    // half a bit to the start centre, then one full bit per remaining bit.
    localparam int LAT = 3 + C / 2 + 1 + (9 + NPAR) * BIT;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic       err_clear = 1'b0;
    logic       rx_valid, frame_err, overrun;
    logic [7:0] rx_data;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .err_clear (err_clear)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        int         kind;  // 0 push byte, 1 frame error, 2 parity error
        logic [7:0] data;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] m_fifo[$];
    logic       m_frame = 1'b0, m_over = 1'b0, m_par = 1'b0;
    int         cyc = 0;
    int         checks = 0, errors = 0;
    logic [7:0] log_data[$];
    int         log_cyc[$];
    int         fall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: FIFO contents and sticky flags updated at each clock edge.
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (!reset) begin
            m_fifo.delete();
            ev_q.delete();
            m_frame = 1'b0;
            m_over  = 1'b0;
            m_par   = 1'b0;
        end else begin
            if (rx_ready && m_fifo.size() > 0) void'(m_fifo.pop_front());
            while (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                case (ev_q[0].kind)
                    0: if (m_fifo.size() < D) m_fifo.push_back(ev_q[0].data);
                       else m_over = 1'b1;
                    1: m_frame = 1'b1;
                    default: m_par = 1'b1;
                endcase
                void'(ev_q.pop_front());
            end
            if (err_clear) begin
                m_frame = 1'b0;
                m_over  = 1'b0;
                m_par   = 1'b0;
            end
        end
    end

    // Compare DUT against the model on every cycle out of reset.
    always @(negedge clock) begin
        if (reset) begin
            chk("rx_valid", 32'(rx_valid), 32'(m_fifo.size() > 0));
            if (m_fifo.size() > 0) chk("rx_data", 32'(rx_data), 32'(m_fifo[0]));
            chk("frame_err", 32'(frame_err), 32'(m_frame));
            chk("overrun", 32'(overrun), 32'(m_over));
`ifdef UART_RX_PARITY_EN
            chk("parity_err", 32'(parity_err), 32'(m_par));
`endif
            if (rx_valid && rx_ready) begin
                log_data.push_back(rx_data);
                log_cyc.push_back(cyc);
            end
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                              input int tail, output int f);
        ev_t e;
        logic par_ok;
        @(posedge clock);
        #1;
        f      = cyc;
        par_ok = (NPAR == 0) || (par == ^d);
        e.data = d;
        if (!par_ok) begin
            e.cyc  = f + LAT - BIT;
            e.kind = 2;
            ev_q.push_back(e);
        end
        e.cyc = f + LAT;
        if (!stop) begin
            e.kind = 1;
            ev_q.push_back(e);
        end else if (par_ok) begin
            e.kind = 0;
            ev_q.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (NPAR != 0) drive_bit(par);
        drive_bit(stop);
        if (tail > 0) begin
            rx = 1'b0;
            repeat (tail * BIT) @(posedge clock);
            #1;
        end
        rx = 1'b1;
        repeat (20) @(posedge clock);
        #1;
    endtask

    task automatic pulse_clear();
        @(posedge clock);
        #1 err_clear = 1'b1;
        @(posedge clock);
        #1 err_clear = 1'b0;
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("reset rx_valid", 32'(rx_valid), 32'h0);
        chk("reset rx_data", 32'(rx_data), 32'h0);
        chk("reset frame_err", 32'(frame_err), 32'h0);
        chk("reset overrun", 32'(overrun), 32'h0);
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;

        // Single byte, consumer always ready.
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1, ^8'hA5, 0, fall);
        chk("a5 count", 32'(log_data.size()), 32'd1);
        if (log_data.size() > 0) begin
            chk("a5 data", 32'(log_data[0]), 32'hA5);
            chk("a5 latency", 32'(log_cyc[0] - fall), (NPAR != 0) ? 32'd2282 : 32'd2065);
        end
        log_data.delete();
        log_cyc.delete();

        // Short low glitch on an idle line.
        @(posedge clock);
        #1 rx = 1'b0;
        repeat (50) @(posedge clock);
        #1 rx = 1'b1;
        repeat (300) @(posedge clock);
        #1;
        chk("glitch count", 32'(log_data.size()), 32'd0);

        // Bad stop bit followed by a break.
        send_frame(8'h3C, 1'b0, ^8'h3C, 3, fall);
        chk("frame_err set", 32'(frame_err), 32'h1);
        chk("frame no push", 32'(log_data.size()), 32'd0);
        pulse_clear();
        chk("frame_err cleared", 32'(frame_err), 32'h0);

        // Fill past capacity while the consumer is stalled.
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, ^8'(i), 0, fall);
        chk("ovr rx_valid", 32'(rx_valid), 32'h1);
        chk("ovr flag", 32'(overrun), 32'h1);
        chk("ovr head", 32'(rx_data), 32'h01);
        rx_ready = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        chk("ovr pop count", 32'(log_data.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_data.size(); i++) chk("ovr pop data", 32'(log_data[i]), 32'(i + 1));
        pulse_clear();
        chk("overrun cleared", 32'(overrun), 32'h0);
        log_data.delete();
        log_cyc.delete();

        // Reset during data bit 4; bits 4..7 of 0xF0 keep the line high afterwards.
        fork
            send_frame(8'hF0, 1'b1, ^8'hF0, 0, fall);
            begin
                repeat (5 * BIT + 100) @(posedge clock);
                #1 reset = 1'b0;
                repeat (3) @(posedge clock);
                #1 reset = 1'b1;
            end
        join
        chk("reset abandons", 32'(log_data.size()), 32'd0);
        chk("reset rx_valid2", 32'(rx_valid), 32'h0);
        send_frame(8'h7E, 1'b1, ^8'h7E, 0, fall);
        chk("7e count", 32'(log_data.size()), 32'd1);
        if (log_data.size() > 0) chk("7e data", 32'(log_data[0]), 32'h7E);
        log_data.delete();
        log_cyc.delete();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 0, fall);
        chk("parity_err set", 32'(parity_err), 32'h1);
        chk("parity no push", 32'(log_data.size()), 32'd0);
        pulse_clear();
        chk("parity_err cleared", 32'(parity_err), 32'h0);
        send_frame(8'h07, 1'b1, 1'b1, 0, fall);
        chk("parity good count", 32'(log_data.size()), 32'd1);
        if (log_data.size() > 0) chk("parity good data", 32'(log_data[0]), 32'h07);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
